// File: rtl/gcd_sched_pkg.sv
// gcd_sched_pkg -- types and constants shared by the GCD scheduler slice.
//   DATA_WIDTH         : operand / result width shared with the gcd_dp datapath
//   GCD_NUM_REQ        : default number of requesters
//   GCD_ID_WIDTH       : requester ID width for the default requester count
//   gcd_sched_state_e  : sequencer states
//   gcd_rsp_t          : response bundle {id, gcd, err}
package gcd_sched_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int GCD_NUM_REQ  = 4;
  localparam int GCD_ID_WIDTH = $clog2(GCD_NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_FINISH  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } gcd_sched_state_e;

  typedef struct packed {
    logic [GCD_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   gcd;
    logic                    err;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_sched_if.sv
// gcd_sched_if -- request/response channel of the GCD scheduler.
//   req_valid_i / req_a_i / req_b_i : per-requester request, slice i = requester i
//   req_ready_o                     : one-hot accept back to the requesters
//   rsp_valid_o / rsp_ready_i       : response handshake
//   rsp_id_o / rsp_gcd_o / rsp_err_o: response payload
// Signal names carry the scheduler's point of view (slave = scheduler).
interface gcd_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) ();
  import gcd_sched_pkg::*;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic [ID_WIDTH-1:0]           rsp_id_o;
  logic [DATA_WIDTH-1:0]         rsp_gcd_o;
  logic                          rsp_err_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_gcd_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_gcd_o, rsp_err_o
  );

endinterface

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter -- combinational round-robin arbiter.
//   req        in  NUM_REQ   request vector
//   last_grant in  ID_WIDTH  index granted last time; search starts one above it
//   grant      out NUM_REQ   one-hot winner (zero when nothing requests)
//   grant_idx  out ID_WIDTH  binary index of the winner
//   any_valid  out 1         at least one request present
module gcd_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_valid
);

  logic [ID_WIDTH-1:0] idx;
  logic                found;

  // Walk the requesters starting just above last_grant, wrapping around;
  // the first one found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_WIDTH'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/gcd_sched.sv
// gcd_sched -- round-robin scheduler/sequencer sharing one gcd_dp datapath.
//   clk_i, nreset_i        : clock, synchronous active-low reset
//   bus (gcd_sched_if)     : request/response channel (slave side)
//   dp_operand_a/b_o       : operands latched at accept, held until next accept
//   dp_enable/init/compute/finish_o : datapath phase flags
//   dp_compare_zero_i      : datapath reports next A or B is zero
//   dp_gcd_i               : datapath result
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | arbitrate and accept one request
// INIT     | load datapath with latched operands (one cycle)
// COMPUTE  | datapath iterates; leave on compare_zero or timeout
// FINISH   | datapath final select (one cycle)
// CAPTURE  | register datapath result
// RESP     | present response until rsp_ready_i
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ),
  parameter int MAX_ITER = 2**DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  gcd_sched_if.slave            bus,
  output logic [DATA_WIDTH-1:0] dp_operand_a_o,
  output logic [DATA_WIDTH-1:0] dp_operand_b_o,
  output logic                  dp_enable_o,
  output logic                  dp_init_o,
  output logic                  dp_compute_o,
  output logic                  dp_finish_o,
  input  logic                  dp_compare_zero_i,
  input  logic [DATA_WIDTH-1:0] dp_gcd_i
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_INIT    = ST_INIT;
  localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [2:0] S_FINISH  = ST_FINISH;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_RESP    = ST_RESP;

  logic [2:0]            state_q;
  logic [ID_WIDTH-1:0]   last_grant_q;
  logic [CNT_W-1:0]      iter_cnt_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  gcd_rsp_t              rsp_q;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;

  gcd_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req        (bus.req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  // One-hot grant turns the operand select into an OR-mux.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = bus.req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel = bus.req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      iter_cnt_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            op_a_q       <= a_sel;
            op_b_q       <= b_sel;
            last_grant_q <= grant_idx;
            rsp_q.id     <= GCD_ID_WIDTH'(grant_idx);
            iter_cnt_q   <= '0;
            // A zero operand makes the other operand the answer.
            if ((a_sel == '0) || (b_sel == '0)) begin
              rsp_q.gcd <= a_sel | b_sel;
              rsp_q.err <= 1'b0;
              state_q   <= S_RESP;
            end else begin
              state_q <= S_INIT;
            end
          end
        end
        S_INIT: state_q <= S_COMPUTE;
        S_COMPUTE: begin
          iter_cnt_q <= iter_cnt_q + CNT_W'(1);
          // compare_zero wins over timeout in the same cycle
          if (dp_compare_zero_i) begin
            state_q <= S_FINISH;
          end else if (iter_cnt_q == CNT_W'(MAX_ITER - 1)) begin
            rsp_q.gcd <= '0;
            rsp_q.err <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_FINISH: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          rsp_q.gcd <= dp_gcd_i;
          rsp_q.err <= 1'b0;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE) ? grant : '0;
  assign bus.rsp_valid_o = (state_q == S_RESP);
  assign bus.rsp_id_o    = ID_WIDTH'(rsp_q.id);
  assign bus.rsp_gcd_o   = rsp_q.gcd;
  assign bus.rsp_err_o   = rsp_q.err;

  assign dp_operand_a_o = op_a_q;
  assign dp_operand_b_o = op_b_q;
  assign dp_enable_o    = (state_q == S_INIT) || (state_q == S_COMPUTE) || (state_q == S_FINISH);
  assign dp_init_o      = (state_q == S_INIT);
  assign dp_compute_o   = (state_q == S_COMPUTE);
  assign dp_finish_o    = (state_q == S_FINISH);

endmodule
